pad_dir_sequencer: RTL and testbench
====================================

PAD_DIR_SEQUENCER -- requirements
Module: pad_dir_sequencer

Interface
REQ-001 Parameter SETTLE, default 4: number of cycles a pad is held in the safe state before its new mode is applied; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 nreset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  host request to change one pad's mode.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_side  input  2  target side: 0=we, 1=no, 2=so, 3=ea.
REQ-007 req_pad  input  4  pad index within the side; 0..8 legal.
REQ-008 req_mode  input  2  0=off (ie=0,oen=1), 1=input (ie=1,oen=1), 2=output (ie=0,oen=0), 3=bidir (ie=1,oen=0).
REQ-009 safe_all  input  1  force every pad to off immediately.
REQ-010 resp_valid  output  1  one-cycle pulse: request completed.
REQ-011 resp_err  output  1  qualifies resp_valid; 1 = request rejected or aborted.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 we_ie, no_ie, so_ie, ea_ie  output  9 each  per-pad input enable to the core pad ring.
REQ-014 we_oen, no_oen, so_oen, ea_oen  output  9 each  per-pad active-low output enable to the core pad ring.

Function
REQ-015 FSM states: IDLE, SAFE, RESP; all outputs are registered.
REQ-016 req_ready = 1 only in IDLE with safe_all = 0.
REQ-017 Handshake: a request is accepted on a rising edge where req_valid & req_ready; side, pad and mode are latched at that edge.
REQ-018 A per-pad 2-bit mode register (36 total) holds the current mode; ie/oen outputs are decoded from it per REQ-008.
REQ-019 Accept with req_pad > 8: no pad changes; next state RESP with resp_err=1.
REQ-020 Accept with legal pad and req_mode equal to the current mode: no pad changes; next state RESP with resp_err=0.
REQ-021 Accept with legal pad and a different mode: on the same edge the pad's mode register is set to off (ie=0, oen=1); next state SAFE; settle counter loaded with SETTLE-1.
REQ-022 SAFE: the counter decrements each cycle; on the edge where it reads 0, the pad's mode register takes the latched mode and the next state is RESP.
REQ-023 RESP: resp_valid=1 for exactly one cycle; next state IDLE.
REQ-024 Latency for a mode change: resp_valid is high SETTLE+1 cycles after the accept edge, and the pad is off for exactly SETTLE cycles. Latency for no-op or error: 1 cycle.
REQ-025 The target pad never passes directly between any two of input, output and bidir without the off state; no pad other than the target changes.
REQ-026 safe_all=1 at an edge: all 36 mode registers go to off. If the FSM is in SAFE, the request is aborted and the next state is RESP with resp_err=1. If it is in RESP, that response completes unchanged. If it is in IDLE, it stays IDLE and no request is accepted.
REQ-027 safe_all held high keeps all pads off and req_ready low.

Reset
REQ-028 While nreset=0: state IDLE, all mode registers off, so every *_ie=9'h000 and every *_oen=9'h1FF; resp_valid=0, resp_err=0, busy=0, counter=0.
REQ-029 Reset asserted mid-sequence aborts the request with no response pulse; after release the block is in IDLE with req_ready=1.

Verification
REQ-030 After reset, req side=2, pad=5, mode=2 with SETTLE=4 -> so_oen[5] stays 1 for 4 cycles, then goes to 0; resp_valid is high 5 cycles after the accept edge with resp_err=0; so_oen otherwise stays 9'h1FF.
REQ-031 ea pad 0 currently in output mode, request mode=1 -> ea_oen[0]=1 and ea_ie[0]=0 for SETTLE cycles, then ea_ie[0]=1 and ea_oen[0]=1; no cycle has ie=1 and oen=0.
REQ-032 req pad=12 -> resp_valid with resp_err=1 one cycle after accept; all ie/oen outputs unchanged.
REQ-033 Request mode equal to the current mode -> resp_valid with resp_err=0 after 1 cycle; the pad never enters the off state.
REQ-034 safe_all pulse 2 cycles into SAFE, with several pads previously in output mode -> all *_oen=9'h1FF and all *_ie=0 on the next edge; resp_valid=1 with resp_err=1; aborted pad stays off.
REQ-035 nreset asserted during SAFE, then released -> outputs at reset values asynchronously; no resp_valid; the next request is accepted normally.

Source files
------------

// File: rtl/pad_dir_sequencer.sv
// Pad direction sequencer: moves one pad at a time between off/input/output/bidir,
// always parking it in the off state for SETTLE cycles before applying the new mode.
module pad_dir_sequencer #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_side,
  input  logic [3:0] req_pad,
  input  logic [1:0] req_mode,
  input  logic       safe_all,
  output logic       resp_valid,
  output logic       resp_err,
  output logic       busy,
  output logic [8:0] we_ie,
  output logic [8:0] no_ie,
  output logic [8:0] so_ie,
  output logic [8:0] ea_ie,
  output logic [8:0] we_oen,
  output logic [8:0] no_oen,
  output logic [8:0] so_oen,
  output logic [8:0] ea_oen
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SAFE = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] MODE_OFF = 2'd0;

  logic [1:0] state;
  logic [3:0] cnt;
  logic [1:0] side_q;
  logic [3:0] pad_q;
  logic [1:0] mode_q;
  logic       err_q;
  logic       accept;
  logic       settle_done;
  logic [1:0] cur_mode;

  // Mode encoding is chosen so that bit 0 is ie and bit 1 is ~oen.
  logic [1:0] pad_mode [4][9];

  assign req_ready   = (state == ST_IDLE) && !safe_all;
  assign accept      = req_valid && req_ready;
  assign busy        = (state != ST_IDLE);
  assign settle_done = (state == ST_SAFE) && (cnt == 4'd0);

  always_comb begin
    cur_mode = MODE_OFF;
    for (int unsigned s = 0; s < 4; s++) begin
      for (int unsigned p = 0; p < 9; p++) begin
        if (req_side == 2'(s) && req_pad == 4'(p)) cur_mode = pad_mode[s][p];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      side_q     <= '0;
      pad_q      <= '0;
      mode_q     <= '0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= (state == ST_RESP);
      resp_err   <= (state == ST_RESP) && err_q;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            side_q <= req_side;
            pad_q  <= req_pad;
            mode_q <= req_mode;
            if (req_pad > 4'd8) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else if (cur_mode == req_mode) begin
              err_q <= 1'b0;
              state <= ST_RESP;
            end else begin
              err_q <= 1'b0;
              cnt   <= 4'(SETTLE - 1);
              state <= ST_SAFE;
            end
          end
        end
        ST_SAFE: begin
          if (safe_all) begin
            err_q <= 1'b1;
            cnt   <= '0;
            state <= ST_RESP;
          end else if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // safe_all outranks both the park-on-accept and the final mode apply.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned s = 0; s < 4; s++) begin
        for (int unsigned p = 0; p < 9; p++) pad_mode[s][p] <= MODE_OFF;
      end
    end else begin
      for (int unsigned s = 0; s < 4; s++) begin
        for (int unsigned p = 0; p < 9; p++) begin
          if (safe_all) begin
            pad_mode[s][p] <= MODE_OFF;
          end else if (accept && req_side == 2'(s) && req_pad == 4'(p) &&
                       req_mode != pad_mode[s][p]) begin
            pad_mode[s][p] <= MODE_OFF;
          end else if (settle_done && side_q == 2'(s) && pad_q == 4'(p)) begin
            pad_mode[s][p] <= mode_q;
          end
        end
      end
    end
  end

  always_comb begin
    we_ie = '0; no_ie = '0; so_ie = '0; ea_ie = '0;
    we_oen = '1; no_oen = '1; so_oen = '1; ea_oen = '1;
    for (int unsigned p = 0; p < 9; p++) begin
      we_ie[p]  = pad_mode[0][p][0];
      no_ie[p]  = pad_mode[1][p][0];
      so_ie[p]  = pad_mode[2][p][0];
      ea_ie[p]  = pad_mode[3][p][0];
      we_oen[p] = ~pad_mode[0][p][1];
      no_oen[p] = ~pad_mode[1][p][1];
      so_oen[p] = ~pad_mode[2][p][1];
      ea_oen[p] = ~pad_mode[3][p][1];
    end
  end

endmodule

// File: tb/tb_pad_dir_sequencer.sv
// Directed self-checking bench for pad_dir_sequencer with SETTLE=4.
module tb_pad_dir_sequencer;

  localparam int unsigned SETTLE = 4;
  localparam logic [71:0] ALL_OFF = {36'h0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};

  logic       clk = 1'b0;
  logic       nreset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_side;
  logic [3:0] req_pad;
  logic [1:0] req_mode;
  logic       safe_all;
  logic       resp_valid;
  logic       resp_err;
  logic       busy;
  logic [8:0] we_ie, no_ie, so_ie, ea_ie;
  logic [8:0] we_oen, no_oen, so_oen, ea_oen;
  logic [71:0] pads;

  int checks = 0;
  int errors = 0;

  pad_dir_sequencer #(.SETTLE(SETTLE)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_side(req_side), .req_pad(req_pad), .req_mode(req_mode),
    .safe_all(safe_all),
    .resp_valid(resp_valid), .resp_err(resp_err), .busy(busy),
    .we_ie(we_ie), .no_ie(no_ie), .so_ie(so_ie), .ea_ie(ea_ie),
    .we_oen(we_oen), .no_oen(no_oen), .so_oen(so_oen), .ea_oen(ea_oen)
  );

  assign pads = {we_ie, no_ie, so_ie, ea_ie, we_oen, no_oen, so_oen, ea_oen};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic [1:0] s, input logic [3:0] p, input logic [1:0] m);
    req_side = s; req_pad = p; req_mode = m; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for ready, issues one request, then waits (bounded) for the response.
  task automatic do_req(input logic [1:0] s, input logic [3:0] p, input logic [1:0] m,
                        output int lat, output logic err);
    int w = 0;
    while (!req_ready && w < 50) begin tick(); w++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL do_req_ready: req_ready=%b required 1", req_ready);
    end
    accept_req(s, p, m);
    lat = -1; err = 1'bx;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (resp_valid) begin lat = i; err = resp_err; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL do_req_timeout: no resp_valid within 40 cycles");
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0; req_valid = 1'b0; req_side = '0; req_pad = '0; req_mode = '0; safe_all = 1'b0;
    tick(); tick();
    checks++; if (pads !== ALL_OFF) begin errors++; $display("FAIL reset_pads: got %h required %h", pads, ALL_OFF); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b%b required 00", resp_valid, resp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    nreset = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_mode_change;
    logic [8:0] exp_oen;
    accept_req(2'd2, 4'd5, 2'd2);
    for (int i = 0; i <= 6; i++) begin
      exp_oen = (i >= 4) ? 9'h1DF : 9'h1FF;
      checks++; if (so_oen !== exp_oen) begin errors++; $display("FAIL chg_so_oen[%0d]: got %h required %h", i, so_oen, exp_oen); end
      checks++; if (so_ie !== 9'h000) begin errors++; $display("FAIL chg_so_ie[%0d]: got %h required 000", i, so_ie); end
      checks++; if (resp_valid !== (i == 5)) begin errors++; $display("FAIL chg_resp_valid[%0d]: got %b required %b", i, resp_valid, (i == 5)); end
      if (i == 5) begin
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL chg_resp_err: got %b required 0", resp_err); end
      end
      checks++; if (busy !== (i < 5)) begin errors++; $display("FAIL chg_busy[%0d]: got %b required %b", i, busy, (i < 5)); end
      tick();
    end
  endtask

  task automatic test_no_direct_switch;
    int lat; logic err; int off_cnt = 0; int bad = 0; int rv_at = -1;
    do_req(2'd3, 4'd0, 2'd2, lat, err);
    checks++; if (lat !== 5 || err !== 1'b0) begin errors++; $display("FAIL sw_setup: lat=%0d err=%b required 5/0", lat, err); end
    checks++; if (ea_oen !== 9'h1FE || ea_ie !== 9'h000) begin errors++; $display("FAIL sw_setup_pad: oen=%h ie=%h required 1FE/000", ea_oen, ea_ie); end
    accept_req(2'd3, 4'd0, 2'd1);
    for (int i = 0; i <= 6; i++) begin
      if (ea_ie[0] && !ea_oen[0]) bad++;
      if (!ea_ie[0] && ea_oen[0]) off_cnt++;
      if (resp_valid && rv_at < 0) rv_at = i;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sw_ie_with_oe: %0d cycles required 0", bad); end
    checks++; if (off_cnt !== SETTLE) begin errors++; $display("FAIL sw_off_cycles: got %0d required %0d", off_cnt, SETTLE); end
    checks++; if (rv_at !== 5) begin errors++; $display("FAIL sw_latency: got %0d required 5", rv_at); end
    checks++; if (ea_ie !== 9'h001 || ea_oen !== 9'h1FF) begin errors++; $display("FAIL sw_final: ie=%h oen=%h required 001/1FF", ea_ie, ea_oen); end
  endtask

  task automatic test_bad_pad;
    logic [71:0] exp_pads;
    exp_pads = {9'h000, 9'h000, 9'h000, 9'h001, 9'h1FF, 9'h1FF, 9'h1DF, 9'h1FF};
    accept_req(2'd1, 4'd12, 2'd2);
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bad_pad_t0: rv=%b busy=%b required 0/1", resp_valid, busy); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL bad_pad_resp: rv=%b err=%b required 1/1", resp_valid, resp_err); end
    checks++; if (pads !== exp_pads) begin errors++; $display("FAIL bad_pad_pads: got %h required %h", pads, exp_pads); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bad_pad_pulse: got %b required 0", resp_valid); end
  endtask

  task automatic test_noop;
    accept_req(2'd2, 4'd5, 2'd2);
    checks++; if (so_oen !== 9'h1DF) begin errors++; $display("FAIL noop_off: so_oen=%h required 1DF", so_oen); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL noop_resp: rv=%b err=%b required 1/0", resp_valid, resp_err); end
    checks++; if (so_oen !== 9'h1DF) begin errors++; $display("FAIL noop_keep: so_oen=%h required 1DF", so_oen); end
    tick();
  endtask

  task automatic test_safe_all;
    int lat; logic err;
    do_req(2'd0, 4'd3, 2'd2, lat, err);
    do_req(2'd1, 4'd8, 2'd3, lat, err);
    checks++; if (we_oen !== 9'h1F7 || no_oen !== 9'h0FF || no_ie !== 9'h100) begin errors++; $display("FAIL safe_setup: we_oen=%h no_oen=%h no_ie=%h required 1F7/0FF/100", we_oen, no_oen, no_ie); end
    accept_req(2'd1, 4'd0, 2'd2);
    tick(); tick();
    safe_all = 1'b1;
    tick();
    checks++; if (pads !== ALL_OFF) begin errors++; $display("FAIL safe_pads: got %h required %h", pads, ALL_OFF); end
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL safe_resp_state: busy=%b rv=%b required 1/0", busy, resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL safe_abort_resp: rv=%b err=%b required 1/1", resp_valid, resp_err); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL safe_ready: got %b required 0", req_ready); end
    req_side = 2'd1; req_pad = 4'd0; req_mode = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL safe_no_accept: busy=%b rv=%b required 0/0", busy, resp_valid); end
    safe_all = 1'b0;
    tick(); tick(); tick();
    checks++; if (pads !== ALL_OFF) begin errors++; $display("FAIL safe_stays_off: got %h required %h", pads, ALL_OFF); end
  endtask

  task automatic test_reset_mid;
    int lat; logic err; int seen = 0;
    accept_req(2'd0, 4'd1, 2'd3);
    tick(); tick();
    #2 nreset = 1'b0;
    #1;
    checks++; if (pads !== ALL_OFF || busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_async: pads=%h busy=%b rv=%b", pads, busy, resp_valid); end
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_pulse: %0d pulses required 0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b required 1", req_ready); end
    do_req(2'd0, 4'd1, 2'd1, lat, err);
    checks++; if (lat !== 5 || err !== 1'b0) begin errors++; $display("FAIL rst_mid_next: lat=%0d err=%b required 5/0", lat, err); end
    checks++; if (we_ie !== 9'h002 || we_oen !== 9'h1FF) begin errors++; $display("FAIL rst_mid_pad: ie=%h oen=%h required 002/1FF", we_ie, we_oen); end
  endtask

  task automatic test_back_to_back;
    int lat; logic err;
    do_req(2'd2, 4'd0, 2'd3, lat, err);
    checks++; if (lat !== 5 || err !== 1'b0) begin errors++; $display("FAIL b2b_first: lat=%0d err=%b required 5/0", lat, err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", req_ready); end
    do_req(2'd2, 4'd0, 2'd3, lat, err);
    checks++; if (lat !== 1 || err !== 1'b0) begin errors++; $display("FAIL b2b_noop: lat=%0d err=%b required 1/0", lat, err); end
    checks++; if (so_ie !== 9'h001 || so_oen !== 9'h1FE) begin errors++; $display("FAIL b2b_pad: ie=%h oen=%h required 001/1FE", so_ie, so_oen); end
  endtask

  initial begin
    test_reset();
    test_mode_change();
    test_no_direct_switch();
    test_bad_pad();
    test_noop();
    test_safe_all();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
